// File: rtl/seq_accum_pkg.sv
// seq_accum_engine shared types and schedule defaults.
// Bit i of each mask is the reset value of schedule entry i.
package seq_accum_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] DEFAULT_CNT_MASK  = 16'h3FFD;
  localparam logic [15:0] DEFAULT_LOAD_MASK = 16'h425F;

  // Entries beyond the 16-bit mask reset to zero.
  function automatic logic default_bit(
    input logic [15:0] mask,
    input int          idx
  );
    logic [3:0] sel;
    sel = idx[3:0];
    if (idx < 16)
      return mask[sel];
    return 1'b0;
  endfunction

endpackage

// File: rtl/seq_accum_engine_seq_prog_mem.sv
// seq_prog_mem: STEPS x {cnt, load} schedule register file.
// One write port, one asynchronous read port, resets to defaults.
module seq_prog_mem
  import seq_accum_pkg::*;
#(
  parameter  int STEPS  = 16,
  localparam int STEP_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [STEP_W-1:0] addr,
  input  logic              wr_cnt,
  input  logic              wr_load,
  input  logic [STEP_W-1:0] rd_addr,
  output logic              rd_cnt,
  output logic              rd_load
);

  logic [STEPS-1:0] cnt_q;
  logic [STEPS-1:0] load_q;

  // Schedule storage: defaults on reset, single entry write otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        cnt_q[i]  <= default_bit(DEFAULT_CNT_MASK, i);
        load_q[i] <= default_bit(DEFAULT_LOAD_MASK, i);
      end
    end else if (we && (int'(addr) < STEPS)) begin
      cnt_q[addr]  <= wr_cnt;
      load_q[addr] <= wr_load;
    end
  end

  assign rd_cnt  = cnt_q[rd_addr];
  assign rd_load = load_q[rd_addr];

endmodule

// File: rtl/seq_accum_engine.sv
// seq_accum_engine: schedule-driven increment/accumulate engine.
// Step pointer walks the schedule; entries drive B and W <= W + B.
module seq_accum_engine
  import seq_accum_pkg::*;
#(
  parameter  int DATA_W = 6,
  parameter  int STEPS  = 16,
  localparam int STEP_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic              cfg_cnt,
  input  logic              cfg_load,
  input  logic              start,
  input  logic              hold,
  input  logic              repeat_mode,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step,
  output logic [DATA_W-1:0] W,
  output logic              overflow
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t state_q;
  state_t state_d;

  logic              clear;
  logic              exec;
  logic              last;
  logic              mem_we;
  logic              ent_cnt;
  logic              ent_load;
  logic [DATA_W-1:0] B;
  logic [DATA_W:0]   sum;

  seq_prog_mem #(
    .STEPS (STEPS)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (mem_we),
    .addr    (cfg_addr),
    .wr_cnt  (cfg_cnt),
    .wr_load (cfg_load),
    .rd_addr (step),
    .rd_cnt  (ent_cnt),
    .rd_load (ent_load)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state and per-cycle datapath controls.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    exec    = 1'b0;
    last    = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_we = cfg_we;
        if (start) begin
          clear   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          exec = 1'b1;
          if (step == LAST_STEP) begin
            last = 1'b1;
            if (!repeat_mode)
              state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign sum  = {1'b0, W} + {1'b0, B};

  // Step pointer, B counter, W accumulator, sticky carry, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      W        <= '0;
      B        <= '0;
      step     <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (clear) begin
        W        <= '0;
        B        <= '0;
        step     <= '0;
        overflow <= 1'b0;
      end else if (exec) begin
        if (ent_load) begin
          W        <= sum[DATA_W-1:0];
          overflow <= overflow | sum[DATA_W];
        end
        if (ent_cnt)
          B <= B + DATA_W'(1);
        if (last)
          step <= '0;
        else
          step <= step + STEP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_accum_engine.sv
// tb_seq_accum_engine: directed runs against a behavioural model.
// Model compared every cycle; literal results pin the model.
module tb_seq_accum_engine;

  localparam int DATA_W = 6;
  localparam int STEPS  = 16;
  localparam int STEP_W = 4;
  localparam int MOD    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_we = 1'b0;
  logic [STEP_W-1:0] cfg_addr = '0;
  logic              cfg_cnt = 1'b0;
  logic              cfg_load = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              repeat_mode = 1'b0;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step;
  logic [DATA_W-1:0] W;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  bit m_run;
  bit m_done;
  bit m_ovf;
  int m_step;
  int m_W;
  int m_B;
  bit s_cnt[STEPS];
  bit s_load[STEPS];

  bit [15:0] dc = 16'h3FFD;
  bit [15:0] dl = 16'h425F;

  seq_accum_engine #(
    .DATA_W (DATA_W),
    .STEPS  (STEPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_cnt     (cfg_cnt),
    .cfg_load    (cfg_load),
    .start       (start),
    .hold        (hold),
    .repeat_mode (repeat_mode),
    .busy        (busy),
    .done        (done),
    .step        (step),
    .W           (W),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: the engine as a stepping interpreter.
  always @(posedge clk) begin
    if (reset) begin
      m_run  = 0;
      m_done = 0;
      m_ovf  = 0;
      m_step = 0;
      m_W    = 0;
      m_B    = 0;
      for (int i = 0; i < STEPS; i++) begin
        s_cnt[i]  = dc[i];
        s_load[i] = dl[i];
      end
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (cfg_we && int'(cfg_addr) < STEPS) begin
          s_cnt[cfg_addr]  = cfg_cnt;
          s_load[cfg_addr] = cfg_load;
        end
        if (start) begin
          m_run  = 1;
          m_step = 0;
          m_W    = 0;
          m_B    = 0;
          m_ovf  = 0;
        end
      end else if (!hold) begin
        if (s_load[m_step]) begin
          if (m_W + m_B >= MOD) m_ovf = 1;
          m_W = (m_W + m_B) % MOD;
        end
        if (s_cnt[m_step]) m_B = (m_B + 1) % MOD;
        if (m_step == STEPS - 1) begin
          m_done = 1;
          m_step = 0;
          if (!repeat_mode) m_run = 0;
        end else begin
          m_step++;
        end
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("step", 32'(step), m_step);
      chk("W", 32'(W), m_W);
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    armed = 1;
  endtask

  // Start in the current cycle (cycle 0) and follow the run.
  task automatic run_test(input int hold_at, input int inj_at,
                          input int rst_at, input bit rep,
                          output int d1, output int d2);
    int n;
    bit fin;
    n   = 1;
    d1  = -1;
    d2  = -1;
    fin = 0;
    repeat_mode = rep;
    start = 1;
    @(posedge clk); #1;
    start  = 0;
    cfg_we = 0;
    for (int k = 0; k < 200; k++) begin
      hold     = (hold_at > 0) && (n >= hold_at) && (n < hold_at + 3);
      start    = (n == inj_at);
      cfg_we   = (n == inj_at);
      cfg_addr = '0;
      cfg_cnt  = 1'b1;
      cfg_load = 1'b1;
      reset    = (n == rst_at);
      @(negedge clk);
      if (n == rst_at) begin
        @(posedge clk); #1;
        reset = 0;
        fin   = 1;
        break;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = n;
          repeat_mode = 0;
          if (!rep) begin
            fin = 1;
            break;
          end
        end else begin
          d2  = n;
          fin = 1;
          break;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    hold   = 0;
    start  = 0;
    cfg_we = 0;
    if (!fin) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int d1;
    int d2;

    do_reset();
    @(negedge clk);
    chk("rst_W", 32'(W), 0);
    chk("rst_busy", 32'(busy), 0);

    @(posedge clk); #1;
    run_test(0, 0, 0, 0, d1, d2);
    chk("t1_done_cyc", d1, 17);
    chk("t1_W", 32'(W), 33);
    chk("t1_ovf", 32'(overflow), 0);

    @(posedge clk); #1;
    run_test(6, 0, 0, 0, d1, d2);
    chk("hold_done_cyc", d1, 20);
    chk("hold_W", 32'(W), 33);

    @(posedge clk); #1;
    run_test(0, 4, 0, 0, d1, d2);
    chk("busy_ign_cyc", d1, 17);
    chk("busy_ign_W", 32'(W), 33);

    @(posedge clk); #1;
    run_test(0, 0, 8, 0, d1, d2);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_W", 32'(W), 0);
    @(posedge clk); #1;
    run_test(0, 0, 0, 0, d1, d2);
    chk("after_rst_W", 32'(W), 33);

    @(posedge clk); #1;
    run_test(0, 0, 0, 1, d1, d2);
    chk("rep_done1", d1, 17);
    chk("rep_done2", d2, 33);
    chk("rep_W", 32'(W), 42);
    chk("rep_ovf", 32'(overflow), 1);

    @(posedge clk); #1;
    cfg_we   = 1;
    cfg_addr = 4'd15;
    cfg_cnt  = 0;
    cfg_load = 1;
    run_test(0, 0, 0, 0, d1, d2);
    chk("wr_start_W", 32'(W), 46);
    chk("wr_start_ovf", 32'(overflow), 0);

    do_reset();
    for (int i = 0; i < STEPS; i++) begin
      cfg_we   = 1;
      cfg_addr = STEP_W'(i);
      cfg_cnt  = 1;
      cfg_load = 1;
      @(posedge clk); #1;
    end
    cfg_we = 0;
    run_test(0, 0, 0, 0, d1, d2);
    chk("all_W", 32'(W), 56);
    chk("all_ovf", 32'(overflow), 1);
    chk("all_done_cyc", d1, 17);

    @(posedge clk); #1;
    armed = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
